// File: rtl/hash_arb_pkg.sv
// Shared types and widths for the hash_phase arbiter.
// Holds the pass-sequencer state encoding and a saturating counter helper.
package hash_arb_pkg;

    localparam int DATA_W = 64;
    localparam int STAT_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/hash_arb_tag_fifo.sv
// In-order requester-ID FIFO; head is first-word-fall-through, 1-cycle push-to-head.
// Pushes while full and pops while empty are ignored.
module hash_arb_tag_fifo #(
    parameter int ID_W  = 2,
    parameter int DEPTH = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  logic [ID_W-1:0] push_dat_i,
    input  logic            pop_i,
    output logic            full_o,
    output logic            empty_o,
    output logic [ID_W-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [ID_W-1:0] mem_q [DEPTH];
    logic [AW:0]     wr_ptr_q;
    logic [AW:0]     rd_ptr_q;
    logic            do_push;
    logic            do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
        end
    end

endmodule

// File: rtl/hash_arbiter.sv
// Round-robin share of one hash_phase among NUM_REQ readers; admit is 0-cycle, return 1 cycle after pop.
// Admit stalls on hash_phase afull or full tag FIFO; return stalls head-of-line on the head lane's afull. Optional stats: HASH_ARB_STATS_EN.
module hash_arbiter
    import hash_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int TAG_DEPTH = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_in,
    output logic                      done,
    input  logic [NUM_REQ-1:0]        req_valid_in,
    input  logic [NUM_REQ-1:0]        req_last_in,
    input  logic [NUM_REQ*DATA_W-1:0] req_value_in,
    output logic [NUM_REQ-1:0]        req_ready_out,
    input  logic                      hp_afull_in,
    output logic                      hp_write_en_out,
    output logic [DATA_W-1:0]         hp_value_out,
    input  logic                      hp_empty_in,
    output logic                      hp_read_en_out,
    input  logic [DATA_W-1:0]         hp_value_in,
    input  logic [DATA_W-1:0]         hp_hash_in,
    input  logic [NUM_REQ-1:0]        out_afull_in,
    output logic                      out_valid_out,
    output logic [ID_W-1:0]           out_id_out,
    output logic [DATA_W-1:0]         out_value_out,
    output logic [DATA_W-1:0]         out_hash_out
`ifdef HASH_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0] stat_admit_out,
    output logic [STAT_W-1:0]         stat_stall_out
`endif
);

    arb_state_e          state_q;
    logic                done_q;
    logic [ID_W-1:0]     rr_q;
    logic [NUM_REQ-1:0]  fin_q;

    logic                gnt_vld;
    logic [ID_W-1:0]     gnt_id;
    logic [ID_W-1:0]     rr_d;
    logic                can_admit;
    logic                admit;

    logic                tag_full;
    logic                tag_empty;
    logic [ID_W-1:0]     tag_head;

    logic                out_valid_q;
    logic [ID_W-1:0]     out_id_q;
    logic [DATA_W-1:0]   out_value_q;
    logic [DATA_W-1:0]   out_hash_q;

    function automatic logic [ID_W-1:0] lane_at(input logic [ID_W-1:0] base, input int off);
        int s;
        s = (int'(base) + off) % NUM_REQ;
        return ID_W'(s);
    endfunction

    // Scan from the farthest offset down so the nearest eligible lane wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid_in[lane_at(rr_q, k)] && !fin_q[lane_at(rr_q, k)]) begin
                gnt_vld = 1'b1;
                gnt_id  = lane_at(rr_q, k);
            end
        end
    end

    assign can_admit = (state_q == RUN) && !hp_afull_in && !tag_full;
    assign admit     = can_admit && gnt_vld;
    assign rr_d      = lane_at(gnt_id, 1);

    always_comb begin
        req_ready_out = '0;
        if (admit) begin
            req_ready_out[gnt_id] = 1'b1;
        end
    end

    assign hp_write_en_out = admit;
    assign hp_value_out    = admit ? req_value_in[int'(gnt_id)*DATA_W +: DATA_W] : '0;

    // An empty tag FIFO blocks the pop even if hash_phase claims data.
    assign hp_read_en_out = !hp_empty_in && !tag_empty && !out_afull_in[tag_head];

    hash_arb_tag_fifo #(
        .ID_W  (ID_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (admit),
        .push_dat_i (gnt_id),
        .pop_i      (hp_read_en_out),
        .full_o     (tag_full),
        .empty_o    (tag_empty),
        .head_o     (tag_head)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            rr_q    <= '0;
            fin_q   <= '0;
        end else begin
            if (admit) begin
                rr_q <= rr_d;
                if (req_last_in[gnt_id]) begin
                    fin_q[gnt_id] <= 1'b1;
                end
            end
            case (state_q)
                IDLE, DONE: begin
                    if (start_in) begin
                        state_q <= RUN;
                        done_q  <= 1'b0;
                        fin_q   <= '0;
                    end
                end
                RUN: begin
                    if (&fin_q) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (tag_empty && hp_empty_in) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_value_q <= '0;
            out_hash_q  <= '0;
        end else begin
            out_valid_q <= hp_read_en_out;
            if (hp_read_en_out) begin
                out_id_q    <= tag_head;
                out_value_q <= hp_value_in;
                out_hash_q  <= hp_hash_in;
            end
        end
    end

    assign done          = done_q;
    assign out_valid_out = out_valid_q;
    assign out_id_out    = out_id_q;
    assign out_value_out = out_value_q;
    assign out_hash_out  = out_hash_q;

`ifdef HASH_ARB_STATS_EN
    logic [NUM_REQ-1:0][STAT_W-1:0] stat_admit_q;
    logic [STAT_W-1:0]              stat_stall_q;
    logic                           start_acc;

    assign start_acc = start_in && ((state_q == IDLE) || (state_q == DONE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_admit_q <= '0;
            stat_stall_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (start_acc) begin
                    stat_admit_q[i] <= '0;
                end else if (admit && (int'(gnt_id) == i)) begin
                    stat_admit_q[i] <= sat_inc(stat_admit_q[i]);
                end
            end
            if (((state_q == RUN) || (state_q == DRAIN)) && (|req_valid_in) && !admit) begin
                stat_stall_q <= sat_inc(stat_stall_q);
            end
        end
    end

    assign stat_admit_out = stat_admit_q;
    assign stat_stall_out = stat_stall_q;
`endif

endmodule
